// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller: state encoding and the
// field / control-word encodings used by the sequencer and the condition unit.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    // Instruction op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // Data-processing cmd field (funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ALU control
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU source B select
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Condition field
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Map a data-processing cmd to an ALU operation; unknown cmds act as ADD.
    function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: cmd_to_alu = ALU_ADD;
            CMD_SUB: cmd_to_alu = ALU_SUB;
            CMD_AND: cmd_to_alu = ALU_AND;
            CMD_ORR: cmd_to_alu = ALU_ORR;
            CMD_CMP: cmd_to_alu = ALU_SUB;
            default: cmd_to_alu = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Condition unit: holds the {N,Z,C,V} flags register and evaluates the
// instruction condition against the current (pre-update) flags.
module cond_check
    import multicycle_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic       flag_en_i,
    output logic       condex_o,
    output logic [3:0] flags_o
);

    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;
    assign flags_o      = flags;

    // Evaluate the condition field against the stored flags
    always_comb begin
        condex_o = 1'b0;
        case (cond_i)
            COND_EQ: condex_o = z;
            COND_NE: condex_o = !z;
            COND_CS: condex_o = c;
            COND_CC: condex_o = !c;
            COND_MI: condex_o = n;
            COND_PL: condex_o = !n;
            COND_VS: condex_o = v;
            COND_VC: condex_o = !v;
            COND_HI: condex_o = c & !z;
            COND_LS: condex_o = !c | z;
            COND_GE: condex_o = (n == v);
            COND_LT: condex_o = (n != v);
            COND_GT: condex_o = !z & (n == v);
            COND_LE: condex_o = z | (n != v);
            COND_AL: condex_o = 1'b1;
            default: condex_o = 1'b0;
        endcase
    end

    // Flags load only when the executing instruction sets flags and passes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags <= 4'b0000;
        end else if (flag_en_i && condex_o) begin
            flags <= alu_flags_i;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer: walks the shared-memory datapath through
// fetch/decode/execute/memory/writeback and drives all enables and selects.
// Optional retired-instruction counter enabled by MULTICYCLE_CTRL_PERF_EN.
// state_o and flags_o expose the FSM state and flags register for debug.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [19:0]       instr_i,
    input  logic [3:0]        alu_flags_i,
    output logic              pc_write_o,
    output logic              adr_src_o,
    output logic              mem_write_o,
    output logic              ir_write_o,
    output logic              reg_write_o,
    output logic [1:0]        result_src_o,
    output logic              alu_src_a_o,
    output logic [1:0]        alu_src_b_o,
    output logic [1:0]        alu_control_o,
    output logic [1:0]        imm_src_o,
    output logic [1:0]        reg_src_o,
    output logic [PERF_W-1:0] retired_o,
    output logic [3:0]        state_o,
    output logic [3:0]        flags_o
);

    // instr_i holds instruction bits [31:12]
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       unused_instr_bits;

    assign cond  = instr_i[19:16];
    assign op    = instr_i[15:14];
    assign funct = instr_i[13:8];
    assign rd    = instr_i[3:0];
    assign cmd   = funct[4:1];
    assign unused_instr_bits = &{1'b0, instr_i[7:4]};

    state_t state, next_state;
    logic   condex;
    logic   flag_en;
    logic   regw, branch, mem_write_raw, ir_write_raw;
    logic   is_cmp;

    assign state_o = state;

    cond_check u_cond_check (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cond_i      (cond),
        .alu_flags_i (alu_flags_i),
        .flag_en_i   (flag_en),
        .condex_o    (condex),
        .flags_o     (flags_o)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_MEM:  next_state = MEMADR;
                    OP_DP:   next_state = funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    // Per-state datapath selects and raw (ungated) enables
    always_comb begin
        adr_src_o     = 1'b0;
        result_src_o  = RES_ALUOUT;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = SRCB_RD2;
        alu_control_o = ALU_ADD;
        regw          = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        case (state)
            FETCH: begin
                ir_write_raw = 1'b1;
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALU;
            end
            DECODE: begin
                // PC+4 again so R15 reads see PC+8
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALU;
            end
            MEMADR: begin
                alu_src_b_o   = SRCB_IMM;
                alu_control_o = funct[3] ? ALU_ADD : ALU_SUB;
            end
            MEMREAD: adr_src_o = 1'b1;
            MEMWB: begin
                result_src_o = RES_DATA;
                regw         = 1'b1;
            end
            MEMWRITE: begin
                adr_src_o     = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTER: alu_control_o = cmd_to_alu(cmd);
            EXECUTEI: begin
                alu_src_b_o   = SRCB_IMM;
                alu_control_o = cmd_to_alu(cmd);
            end
            ALUWB: regw = 1'b1;
            BRANCH: begin
                alu_src_b_o  = SRCB_IMM;
                result_src_o = RES_ALU;
                branch       = 1'b1;
            end
            default: ;
        endcase
    end

    // Condition-gated enables; all architectural writes are held off in reset
    always_comb begin
        is_cmp      = (op == OP_DP) && (cmd == CMD_CMP);
        flag_en     = ((state == EXECUTER) || (state == EXECUTEI)) && funct[0];
        reg_write_o = !rst_i && regw && condex && (rd != 4'd15) && !is_cmp;
        pc_write_o  = !rst_i && ((state == FETCH) ||
                                 (condex && (branch || (regw && (rd == 4'd15)))));
        mem_write_o = !rst_i && mem_write_raw && condex;
        ir_write_o  = !rst_i && ir_write_raw;
        imm_src_o   = op;
        reg_src_o   = {op == OP_MEM, op == OP_BR};
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [PERF_W-1:0] retired;
    logic              retire;

    assign retire = (state == MEMWB) || (state == MEMWRITE) || (state == ALUWB) ||
                    (state == BRANCH) || ((state == DECODE) && (op == OP_NOP));
    assign retired_o = retired;

    // Count every instruction that completes, executed or squashed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign retired_o = '0;
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main sequencer for the multicycle variant of the ARM-subset core.
- Steps a shared-memory datapath (one ALU, one memory port, instruction register) through fetch, decode, execute, memory and writeback states.
- Holds the condition flags and generates all datapath enables and mux selects.
- Sits beside the multicycle datapath inside the processor top. It replaces the single-cycle decoder when the core is built for unified instruction/data memory.

Parameters:
- PERF_W, 32, width of the optional retired-instruction counter.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- instr_i  in  20  instruction-register bits [31:12]: cond[31:28], op[27:26], funct[25:20], rd[15:12]
- alu_flags_i  in  4  {N,Z,C,V} from datapath ALU, valid in the same cycle
- pc_write_o  out  1  PC register enable
- adr_src_o  out  1  memory address select: 0=PC, 1=ALU result register
- mem_write_o  out  1  memory write enable
- ir_write_o  out  1  instruction register enable
- reg_write_o  out  1  register file write enable
- result_src_o  out  2  result select: 00=ALUOut reg, 01=Data reg, 10=ALU direct
- alu_src_a_o  out  1  0=RD1 reg, 1=PC
- alu_src_b_o  out  2  00=RD2 reg, 01=ExtImm, 10=constant 4
- alu_control_o  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- imm_src_o  out  2  00=8-bit DP, 01=12-bit mem, 10=24-bit branch
- reg_src_o  out  2  [0]: RA1 = PC(15) for branch; [1]: RA2 = rd for STR
- retired_o  out  PERF_W  retired-instruction count (0 when feature off)

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH. Registered state; all outputs decoded from state plus instr_i plus flags register.
- Reset: state=FETCH, flags=0000, retired=0. While rst_i=1, pc_write, ir_write, reg_write and mem_write are forced to 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: op=01 -> MEMADR; op=00 and funct[5]=0 -> EXECUTER; op=00 and funct[5]=1 -> EXECUTEI; op=10 -> BRANCH; op=11 -> FETCH (NOP).
  - MEMADR: funct[0]=1 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER and EXECUTEI -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
- Per-state outputs (unlisted signals = 0 or don't-care-zero):
  - FETCH: adr_src=0, ir_write=1, alu_src_a=1, alu_src_b=10, ADD, result_src=10, pc_write=1.
  - DECODE: alu_src_a=1, alu_src_b=10, ADD, result_src=10 (PC+8 available on R15 read).
  - MEMADR: alu_src_a=0, alu_src_b=01, ADD; funct[3]=0 selects SUB (negative offset).
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, regw.
  - MEMWRITE: adr_src=1, mem_write = condex.
  - EXECUTER: alu_src_b=00, ALU op from cmd. EXECUTEI: same with alu_src_b=01.
  - ALUWB: result_src=00, regw.
  - BRANCH: alu_src_a=0, alu_src_b=01, ADD, result_src=10, branch.
- cmd decode (funct[4:1]): 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no write). Any other cmd behaves as ADD.
- Writeback and PC gating:
  - reg_write_o = regw & condex & (rd!=15) & !cmp.
  - pc_write_o = FETCH | (condex & (branch | (regw & rd==15))).
- Condition codes, from the flags register:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 -> 0.
- Flags register loads alu_flags_i at the end of EXECUTER/EXECUTEI when funct[0]=1 and condex. Condition evaluation uses the pre-update flags.
- imm_src = op; reg_src[0] = (op==10); reg_src[1] = (op==01).
- Reset asserted mid-instruction aborts it: next cycle is FETCH, no write occurs in the reset cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: retired_o increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or DECODE(op=11). This applies whether or not condex held, and the counter wraps modulo 2^PERF_W.
- Undefined: counter logic is omitted and retired_o is tied to 0.

Decomposition:
- Shared package multicycle_pkg holds:
  - state enum;
  - cond, cmd, op, alu_control, result_src and alu_src_b encodings as localparams.
- One sub-module, cond_check: combinational cond + flags -> condex, plus the flags register and its update enable.

Test Plan:
- Reset for 2 cycles with instr_i=E0812003 (ADD R2,R1,R3) -> state FETCH, flags 0, all write enables 0 during reset.
- ADD R2,R1,R3 (E0812003) -> 4 cycles FETCH/DECODE/EXECUTER/ALUWB; ALUWB: reg_write=1, result_src=00, alu_control=00.
- SUBS R4,R4,#1 (E2544001) with alu_flags_i=0100 -> EXECUTEI; flags=0100 afterwards. Following BNE (1AFFFFFD) -> BRANCH with pc_write=0.
- LDR R5,[R0,#4] (E5905004) -> 5 cycles through MEMREAD/MEMWB; MEMREAD adr_src=1; MEMWB result_src=01, reg_write=1.
- STR with cond EQ (05805000), flags Z=0 -> MEMWRITE with mem_write=0; returns to FETCH.
- MULTICYCLE_CTRL_PERF_EN defined: run 3 instructions -> retired_o=3. Undefined: retired_o stays 0.
